// File: rtl/exu_mul_pipe_ctl.sv
// Pipelined integer multiplier with optional multiply-accumulate, freeze and flush.
// The full result is formed in E1; later stages only carry it to the output register.
module exu_mul_pipe_ctl #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int ACC_EN = 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             freeze,
  input  logic             flush,
  input  logic             valid_in,
  input  logic             rs1_sign,
  input  logic             rs2_sign,
  input  logic             low,
  input  logic             acc,
  input  logic             byp_rs1,
  input  logic             byp_rs2,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] lsu_result,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);

  localparam bit LP_ACC = (ACC_EN != 0);

  logic               r_e1_valid;
  logic [WIDTH-1:0]   r_e1_a;
  logic [WIDTH-1:0]   r_e1_b;
  logic [WIDTH-1:0]   r_e1_c;
  logic               r_e1_s1;
  logic               r_e1_s2;
  logic               r_e1_low;
  logic               r_e1_acc;
  logic               r_e1_byp1;
  logic               r_e1_byp2;

  // Stage 2 receives the E1 result; stage STAGES is the output register.
  logic               r_sv [2:STAGES];
  logic [WIDTH-1:0]   r_sd [2:STAGES];

  logic [WIDTH-1:0]   w_op_a;
  logic [WIDTH-1:0]   w_op_b;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_res;
  logic               w_any_sv;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_e1_valid <= 1'b0;
      r_e1_a     <= '0;
      r_e1_b     <= '0;
      r_e1_c     <= '0;
      r_e1_s1    <= 1'b0;
      r_e1_s2    <= 1'b0;
      r_e1_low   <= 1'b0;
      r_e1_acc   <= 1'b0;
      r_e1_byp1  <= 1'b0;
      r_e1_byp2  <= 1'b0;
    end else if (flush) begin
      r_e1_valid <= 1'b0;
    end else if (!freeze) begin
      r_e1_valid <= valid_in;
      if (valid_in) begin
        r_e1_a    <= a;
        r_e1_b    <= b;
        r_e1_c    <= c;
        r_e1_s1   <= rs1_sign;
        r_e1_s2   <= rs2_sign;
        r_e1_low  <= low;
        r_e1_acc  <= acc;
        r_e1_byp1 <= byp_rs1;
        r_e1_byp2 <= byp_rs2;
      end
    end
  end

  // Load data is taken live in whichever E1 cycle the op actually advances.
  assign w_op_a = r_e1_byp1 ? lsu_result : r_e1_a;
  assign w_op_b = r_e1_byp2 ? lsu_result : r_e1_b;

  // A 2W-bit product of the sign-extended operands equals the truncated
  // (W+1)x(W+1) signed product, covering every signedness combination.
  assign w_ext_a = {{WIDTH{r_e1_s1 & w_op_a[WIDTH-1]}}, w_op_a};
  assign w_ext_b = {{WIDTH{r_e1_s2 & w_op_b[WIDTH-1]}}, w_op_b};
  assign w_prod  = w_ext_a * w_ext_b;

  always_comb begin
    w_res = w_prod[2*WIDTH-1:WIDTH];
    if (LP_ACC && r_e1_acc) begin
      w_res = w_prod[WIDTH-1:0] + r_e1_c;
    end else if (r_e1_low) begin
      w_res = w_prod[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_sv[2] <= 1'b0;
      r_sd[2] <= '0;
    end else if (flush) begin
      r_sv[2] <= 1'b0;
    end else if (!freeze) begin
      r_sv[2] <= r_e1_valid;
      if (r_e1_valid) begin
        r_sd[2] <= w_res;
      end
    end
  end

  generate
    for (genvar gi = 3; gi <= STAGES; gi++) begin : g_stage
      // Data only moves with a valid op, so out keeps its last result.
      always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
          r_sv[gi] <= 1'b0;
          r_sd[gi] <= '0;
        end else if (flush) begin
          r_sv[gi] <= 1'b0;
        end else if (!freeze) begin
          r_sv[gi] <= r_sv[gi-1];
          if (r_sv[gi-1]) begin
            r_sd[gi] <= r_sd[gi-1];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_any_sv = 1'b0;
    for (int k = 2; k <= STAGES; k++) begin
      w_any_sv = w_any_sv | r_sv[k];
    end
  end

  assign out       = r_sd[STAGES];
  assign out_valid = r_sv[STAGES];
  assign busy      = r_e1_valid | w_any_sv;

endmodule
